ipv4_tx_framer: RTL and testbench
=================================

IPV4_TX_FRAMER -- requirements
Module: ipv4_tx_framer

Interface
REQ-001 Parameter TTL, default 8'h40: IP time-to-live field.
REQ-002 Parameter PROTO, default 8'h11: IP protocol field.
REQ-003 Parameter TOS, default 8'h00: IP type-of-service byte.
REQ-004 Parameter ARP_TIMEOUT, default 255: max cycles to wait for r_e.
REQ-005 Parameter ID_INIT, default 16'h0000: identification reset value.
REQ-006 The block SHALL use one clock and a synchronous, active-low reset:
 clk_user_i  in  1  clock.
 reset_n_i  in  1  synchronous active-low reset.
REQ-007 The block SHALL have these ports:
 tx_udp_data_vld_i / tx_udp_data_ready_o  in/out  1  upstream handshake.
 tx_udp_data_i  in  32  payload; byte 0 in [31:24].
 tx_udp_data_be_i  in  4  byte enables; bit 3 is [31:24].
 tx_udp_tlast_i  in  1  last beat.
 tx_udp_tuser_i  in  32  [15:0] UDP length in bytes, including the UDP header.
 tx_udp_target_ip  in  32  destination IP.
 BroadValid_i  in  1  broadcast packet.
 our_mac_i / our_ip_i  in  48/32  local addresses.
 r_en / r_ip_addr  out  1/32  ARP lookup request.
 r_mac_addr / r_e  in  48/1  lookup result and hit strobe.
 tx_ip_req_o / tx_ip_gnt_i  out/in  1  arbiter request and grant.
 tx_ip_data_vld_o / tx_ip_data_ready_i  out/in  1  downstream handshake.
 tx_ip_data_o / tx_ip_data_be_o / tx_ip_data_tlast_o  out  32/4/1  Ethernet frame.
 drop_cnt_o  out  16  ARP-miss drop count, saturating.

Function
REQ-008 The states SHALL be IDLE, LOOKUP, REQ, HDR, PAYLOAD, TAIL and DROP.
REQ-009 IDLE: ready_o=0; on vld_i=1, latch target_ip, tuser[15:0] and BroadValid_i; go to REQ if broadcast, else LOOKUP.
REQ-010 LOOKUP: r_en=1 and r_ip_addr=latched IP until r_e=1 (latch MAC, r_en=0, go to REQ) or ARP_TIMEOUT cycles elapse (r_en=0, go to DROP).
REQ-011 Broadcast SHALL use destination MAC 48'hFFFF_FFFF_FFFF and destination IP 32'hFFFF_FFFF without issuing r_en.
REQ-012 REQ: tx_ip_req_o=1 until the cycle gnt_i=1 is seen, then req=0 and go to HDR.
REQ-013 A downstream word SHALL transfer only when vld_o&&ready_i; data, be and tlast SHALL be held while vld_o&&!ready_i.
REQ-014 HDR SHALL emit W0..W7 with be=4'hF:
 W0 dmac[47:16].
 W1 {dmac[15:0], our_mac[47:32]}.
 W2 our_mac[31:0].
 W3 {16'h0800, 8'h45, TOS}.
 W4 {total_len, ident}.
 W5 {16'h0000, TTL, PROTO}.
 W6 {cksum, our_ip[31:16]}.
 W7 {our_ip[15:0], dip[31:16]}.
REQ-015 total_len SHALL equal udp_len+20, modulo 2^16.
REQ-016 cksum SHALL be the one's-complement of the 16-bit one's-complement sum of all header halfwords with cksum=0, folded until no carry remains; it SHALL be ready before W6 is presented.
REQ-017 PAYLOAD SHALL emit W8={dip[15:0], beat0[31:16]}, then {carry, beat_k[31:16]}, where carry is the previous beat's [15:0].
REQ-018 tx_udp_data_ready_o SHALL be (!vld_o||ready_i) in PAYLOAD only, so one input beat produces one output word with 0-cycle bubble.
REQ-019 Last input beat with k valid bytes: k=1 -> be 4'hE, tlast; k=2 -> be 4'hF, tlast; k=3 or 4 -> be 4'hF, then TAIL emits {carry,16'h0} with be 4'h8 (k=3) or 4'hC (k=4) and tlast.
REQ-020 After the tlast transfer: vld_o=0, tlast=0, ident increments by 1 (wrapping 16'hFFFF->0), go to IDLE.
REQ-021 DROP SHALL hold ready_o=1, discard beats until tlast_i is accepted, increment drop_cnt_o (saturating at 16'hFFFF), leave ident unchanged, and return to IDLE.
REQ-022 Upstream back-pressure mid-packet (vld_i=0) SHALL deassert vld_o without losing carry.

Reset
REQ-023 When reset_n_i=0 at a clock edge: all outputs 0, state IDLE, ident=ID_INIT, drop_cnt_o=0, carry cleared.
REQ-024 Reset mid-packet SHALL abandon the frame with no tlast; the next packet starts from IDLE.

Verification
REQ-025 Unicast: our_ip C0A8010A, target C0A80102, r_e hit after 3 cycles, udp_len 16, 4 beats, last be F, ready_i=1 -> 13 words, W4=0024_0000, W6=F76C_C0A8, last word be C with tlast.
REQ-026 Broadcast=1 -> no r_en; W0=FFFFFFFF; W7[15:0]=FFFF.
REQ-027 r_e never asserted -> r_en drops after 255 cycles; packet drained; drop_cnt_o=1; no req; ident unchanged.
REQ-028 ready_i toggled 1/0 every cycle with last be 8 -> byte-identical frame, final be E with tlast, no duplicated or lost words.
REQ-029 Two back-to-back packets -> second W4[15:0]=ident+1; ident at FFFF wraps to 0000.
REQ-030 reset_n_i=0 during PAYLOAD -> all outputs 0 next cycle; the following packet's frame is correct.

Source files
------------

// File: rtl/ipv4_tx_framer_if.sv
// ipv4_tx_framer_if: word stream bus (valid/ready, 32-bit data, byte enables, last)
//   master drives vld/data/be/tlast and samples ready; slave does the opposite.
interface ipv4_tx_framer_if;
  logic        vld;
  logic        ready;
  logic [31:0] data;
  logic [3:0]  be;
  logic        tlast;
  modport master(output vld, data, be, tlast, input ready);
  modport slave(input vld, data, be, tlast, output ready);
endinterface

// File: rtl/ipv4_tx_framer.sv
// ipv4_tx_framer: wraps a UDP stream into an Ethernet/IPv4 frame with ARP lookup and arbitration
//   clk_user_i/reset_n_i       clock, synchronous active-low reset
//   tx_udp (slave)             upstream UDP beats; tuser[15:0] = UDP length, target IP, broadcast flag
//   our_mac_i/our_ip_i         local addresses
//   r_en/r_ip_addr/r_mac_addr/r_e  ARP table lookup
//   tx_ip_req_o/tx_ip_gnt_i    output arbiter
//   tx_ip (master)             Ethernet frame words, payload realigned by 16 bits
//   drop_cnt_o                 saturating count of packets dropped on ARP miss
module ipv4_tx_framer #(
  parameter logic [7:0]  TTL         = 8'h40,
  parameter logic [7:0]  PROTO       = 8'h11,
  parameter logic [7:0]  TOS         = 8'h00,
  parameter int          ARP_TIMEOUT = 255,
  parameter logic [15:0] ID_INIT     = 16'h0000
) (
  input  logic               clk_user_i,
  input  logic               reset_n_i,
  ipv4_tx_framer_if.slave    tx_udp,
  input  logic [31:0]        tx_udp_tuser_i,
  input  logic [31:0]        tx_udp_target_ip,
  input  logic               BroadValid_i,
  input  logic [47:0]        our_mac_i,
  input  logic [31:0]        our_ip_i,
  output logic               r_en,
  output logic [31:0]        r_ip_addr,
  input  logic [47:0]        r_mac_addr,
  input  logic               r_e,
  output logic               tx_ip_req_o,
  input  logic               tx_ip_gnt_i,
  ipv4_tx_framer_if.master   tx_ip,
  output logic [15:0]        drop_cnt_o
);
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, HDR, PAYLOAD, TAIL, DROP} state_t;
  state_t      state_q;
  logic [47:0] dmac_q;
  logic [31:0] dip_q, data_q;
  logic [15:0] len_q, ident_q, drop_q, carry_q, tmo_q;
  logic [2:0]  widx_q;
  logic [3:0]  be_q, tail_be_q;
  logic        vld_q, tlast_q, req_q, ren_q;
  logic        adv, acc, unused_ok;
  logic [15:0] total_len, cksum;
  logic [19:0] sum;
  logic [16:0] fold;
  logic [31:0] hdr_w;
  assign adv       = !vld_q || tx_ip.ready;
  assign total_len = len_q + 16'd20;
  // Header checksum depends only on latched fields, so it is settled long before W6 is loaded.
  always_comb begin
    sum   = {4'h0, 8'h45, TOS} + {4'h0, total_len} + {4'h0, ident_q} + {4'h0, TTL, PROTO}
          + {4'h0, our_ip_i[31:16]} + {4'h0, our_ip_i[15:0]} + {4'h0, dip_q[31:16]} + {4'h0, dip_q[15:0]};
    fold  = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    cksum = ~(fold[15:0] + {15'h0, fold[16]});
    hdr_w = widx_q == 3'd0 ? dmac_q[47:16] :
            widx_q == 3'd1 ? {dmac_q[15:0], our_mac_i[47:32]} :
            widx_q == 3'd2 ? our_mac_i[31:0] :
            widx_q == 3'd3 ? {16'h0800, 8'h45, TOS} :
            widx_q == 3'd4 ? {total_len, ident_q} :
            widx_q == 3'd5 ? {16'h0000, TTL, PROTO} :
            widx_q == 3'd6 ? {cksum, our_ip_i[31:16]} :
                             {our_ip_i[15:0], dip_q[31:16]};
  end
  assign tx_udp.ready = (state_q == PAYLOAD && adv) || state_q == DROP;
  assign acc          = tx_udp.ready && tx_udp.vld;
  assign tx_ip.vld    = vld_q;
  assign tx_ip.data   = data_q;
  assign tx_ip.be     = be_q;
  assign tx_ip.tlast  = tlast_q;
  assign tx_ip_req_o  = req_q;
  assign r_en         = ren_q;
  assign r_ip_addr    = dip_q;
  assign drop_cnt_o   = drop_q;
  assign unused_ok    = ^{tx_udp_tuser_i[31:16], tx_udp.be[3]};
  always_ff @(posedge clk_user_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      dmac_q    <= '0;
      dip_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      ident_q   <= ID_INIT;
      drop_q    <= '0;
      carry_q   <= '0;
      tmo_q     <= '0;
      widx_q    <= '0;
      be_q      <= '0;
      tail_be_q <= '0;
      vld_q     <= 1'b0;
      tlast_q   <= 1'b0;
      req_q     <= 1'b0;
      ren_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (tx_udp.vld) begin
          len_q <= tx_udp_tuser_i[15:0];
          tmo_q <= '0;
          if (BroadValid_i) begin
            dmac_q  <= '1;
            dip_q   <= '1;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            dip_q   <= tx_udp_target_ip;
            ren_q   <= 1'b1;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          tmo_q <= tmo_q + 16'd1;
          if (r_e) begin
            dmac_q  <= r_mac_addr;
            ren_q   <= 1'b0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else if (tmo_q == 16'(ARP_TIMEOUT - 1)) begin
            ren_q   <= 1'b0;
            state_q <= DROP;
          end
        end
        REQ: if (tx_ip_gnt_i) begin
          req_q   <= 1'b0;
          widx_q  <= '0;
          carry_q <= dip_q[15:0];
          state_q <= HDR;
        end
        HDR: if (adv) begin
          vld_q  <= 1'b1;
          data_q <= hdr_w;
          be_q   <= 4'hF;
          widx_q <= widx_q + 3'd1;
          if (widx_q == 3'd7) state_q <= PAYLOAD;
        end
        PAYLOAD: if (acc) begin
          vld_q   <= 1'b1;
          data_q  <= {carry_q, tx_udp.data[31:16]};
          carry_q <= tx_udp.data[15:0];
          be_q    <= (tx_udp.tlast && !tx_udp.be[2]) ? 4'hE : 4'hF;
          // Three or four bytes in the last beat leave a half word that needs a TAIL word.
          if (tx_udp.tlast) begin
            tlast_q   <= !tx_udp.be[1];
            tail_be_q <= tx_udp.be[0] ? 4'hC : 4'h8;
            state_q   <= TAIL;
          end
        end else if (adv) vld_q <= 1'b0;
        TAIL: if (vld_q && tlast_q) begin
          if (tx_ip.ready) begin
            vld_q   <= 1'b0;
            tlast_q <= 1'b0;
            ident_q <= ident_q + 16'd1;
            state_q <= IDLE;
          end
        end else if (adv) begin
          vld_q   <= 1'b1;
          data_q  <= {carry_q, 16'h0000};
          be_q    <= tail_be_q;
          tlast_q <= 1'b1;
        end
        DROP: if (acc && tx_udp.tlast) begin
          drop_q  <= drop_q == 16'hFFFF ? drop_q : drop_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipv4_tx_framer.sv
// tb_ipv4_tx_framer: directed tests of ipv4_tx_framer against a byte-level frame model
module tb_ipv4_tx_framer;
  localparam logic [47:0] OUR_MAC = 48'h0200_0000_0001;
  localparam logic [31:0] OUR_IP  = 32'hC0A8_010A;
  localparam logic [31:0] TGT     = 32'hC0A8_0102;
  localparam logic [47:0] ARP_MAC = 48'h00AA_BBCC_DDEE;
  logic clk = 0, reset_n = 0, bc = 0;
  logic [31:0] tuser = 0, target = 0, rip;
  logic r_en, r_e = 0, req, gnt = 0;
  logic [15:0] drop_cnt;
  ipv4_tx_framer_if up();
  ipv4_tx_framer_if dn();
  int errors = 0, checks = 0;
  logic [36:0] cap_q[$];
  logic [36:0] got[0:63];
  logic [36:0] stall_w;
  bit stall = 0, toggle = 0, arp_hit = 1, req_prev = 0, ren_seen = 0;
  int ren_cnt = 0, ren_last = 0, req_cnt = 0;
  logic [31:0] rip_seen = 0;

  always #5 clk = ~clk;

  ipv4_tx_framer #(.ID_INIT(16'hFFFF)) dut (
    .clk_user_i(clk), .reset_n_i(reset_n), .tx_udp(up.slave), .tx_udp_tuser_i(tuser),
    .tx_udp_target_ip(target), .BroadValid_i(bc), .our_mac_i(OUR_MAC), .our_ip_i(OUR_IP),
    .r_en(r_en), .r_ip_addr(rip), .r_mac_addr(ARP_MAC), .r_e(r_e),
    .tx_ip_req_o(req), .tx_ip_gnt_i(gnt), .tx_ip(dn.master), .drop_cnt_o(drop_cnt));

  initial begin
    dn.ready = 1;
    forever begin
      @(posedge clk); #1;
      dn.ready = toggle ? ~dn.ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (stall) begin
        checks++;
        if (dn.vld !== 1'b1 || {dn.data, dn.be, dn.tlast} !== stall_w) begin
          errors++;
          $display("FAIL hold: got vld=%b word=%h, want vld=1 word=%h", dn.vld, {dn.data, dn.be, dn.tlast}, stall_w);
        end
      end
      if (dn.vld && dn.ready) cap_q.push_back({dn.data, dn.be, dn.tlast});
      stall = dn.vld && !dn.ready;
      stall_w = {dn.data, dn.be, dn.tlast};
      if (r_en) begin
        ren_cnt++;
        ren_seen = 1;
        rip_seen = rip;
      end else begin
        if (ren_cnt != 0) ren_last = ren_cnt;
        ren_cnt = 0;
      end
      r_e = arp_hit && r_en && ren_cnt == 3;
      gnt = req;
      if (req && !req_prev) req_cnt++;
      req_prev = req;
    end else begin
      stall = 0;
      ren_cnt = 0;
      r_e = 0;
      gnt = 0;
      req_prev = 0;
    end
  end

  function automatic int count_tl();
    int c = 0;
    foreach (cap_q[i]) c += int'(cap_q[i][0]);
    return c;
  endfunction

  task automatic send_pkt(input bit b, input int nbytes, input logic [7:0] seed, input bit gap, input int stop_after);
    int nb, n;
    nb = (nbytes + 3) / 4;
    bc = b;
    target = TGT;
    tuser = 32'(nbytes);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 4; j++) begin
        up.data[31-8*j -: 8] = (4*k + j < nbytes) ? 8'(int'(seed) + 4*k + j) : 8'h00;
        up.be[3-j] = (4*k + j < nbytes);
      end
      up.tlast = (k == nb - 1);
      up.vld = 1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!up.ready && n < 3000);
      if (!up.ready) begin
        errors++;
        checks++;
        $display("FAIL beat_accept: beat %0d ready=%b after %0d cycles, want 1", k, up.ready, n);
        up.vld = 0;
        up.tlast = 0;
        return;
      end
      @(posedge clk); #1;
      if (stop_after == k + 1) begin
        up.vld = 0;
        up.tlast = 0;
        return;
      end
      if (gap && k < nb - 1) begin
        up.vld = 0;
        @(posedge clk); #1;
      end
    end
    up.vld = 0;
    up.tlast = 0;
  endtask

  task automatic wait_tlasts(input int want);
    for (int n = 0; n < 1000 && count_tl() < want; n++) begin
      @(posedge clk); #1;
    end
    if (count_tl() < want) begin
      errors++;
      checks++;
      $display("FAIL frame_end: got %0d tlast words, want %0d", count_tl(), want);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string nm, input logic [47:0] dm, input logic [31:0] dip, input int nbytes,
                             input logic [7:0] seed, input logic [15:0] id, output int nw);
    logic [7:0] fb[0:255];
    logic [47:0] om;
    logic [31:0] oi;
    logic [15:0] tl, ck;
    logic [36:0] exp_w;
    logic [3:0] eb;
    int tot, s, v;
    om = OUR_MAC;
    oi = OUR_IP;
    tot = 34 + nbytes;
    tl = 16'(20 + nbytes);
    for (int i = 0; i < 64; i++) got[i] = '0;
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i] = dm[47-8*i -: 8];
      fb[6+i] = om[47-8*i -: 8];
    end
    fb[12] = 8'h08; fb[14] = 8'h45;
    fb[16] = tl[15:8]; fb[17] = tl[7:0];
    fb[18] = id[15:8]; fb[19] = id[7:0];
    fb[22] = 8'h40; fb[23] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      fb[26+i] = oi[31-8*i -: 8];
      fb[30+i] = dip[31-8*i -: 8];
    end
    for (int i = 0; i < nbytes; i++) fb[34+i] = 8'(int'(seed) + i);
    s = 0;
    for (int i = 14; i < 34; i += 2) s += int'({fb[i], fb[i+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    ck = ~16'(s);
    fb[24] = ck[15:8]; fb[25] = ck[7:0];
    nw = (tot + 3) / 4;
    checks++;
    if (cap_q.size() < nw) begin
      errors++;
      $display("FAIL %s_count: got %0d words, want at least %0d", nm, cap_q.size(), nw);
      cap_q.delete();
      nw = 0;
      return;
    end
    for (int w = 0; w < nw; w++) begin
      v = tot - 4*w;
      if (v > 4) v = 4;
      eb = v == 4 ? 4'hF : v == 3 ? 4'hE : v == 2 ? 4'hC : 4'h8;
      exp_w = {fb[4*w], fb[4*w+1], fb[4*w+2], fb[4*w+3], eb, w == nw - 1};
      got[w] = cap_q.pop_front();
      checks++;
      if (got[w] !== exp_w) begin
        errors++;
        $display("FAIL %s_w%0d: got data=%h be=%h last=%b, want data=%h be=%h last=%b", nm, w,
                 got[w][36:5], got[w][4:1], got[w][0], exp_w[36:5], exp_w[4:1], exp_w[0]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dn.vld, dn.data, dn.be, dn.tlast, req, r_en, rip, up.ready, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b data=%h be=%h last=%b req=%b ren=%b rip=%h rdy=%b drop=%h, want all 0",
               dn.vld, dn.data, dn.be, dn.tlast, req, r_en, rip, up.ready, drop_cnt);
    end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_broadcast();
    int nw;
    cap_q.delete(); ren_seen = 0; req_cnt = 0;
    send_pkt(1, 12, 8'hA0, 0, 0);
    wait_tlasts(1);
    check_frame("bcast", '1, '1, 12, 8'hA0, 16'hFFFF, nw);
    checks++;
    if (ren_seen !== 1'b0) begin errors++; $display("FAIL bcast_ren: got r_en seen=%b, want 0", ren_seen); end
    checks++;
    if (got[0][36:5] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bcast_w0: got %h, want ffffffff", got[0][36:5]); end
    checks++;
    if (got[7][20:5] !== 16'hFFFF) begin errors++; $display("FAIL bcast_w7lo: got %h, want ffff", got[7][20:5]); end
    checks++;
    if (got[4][20:5] !== 16'hFFFF) begin errors++; $display("FAIL bcast_ident: got %h, want ffff", got[4][20:5]); end
    checks++;
    if (dn.vld !== 1'b0 || dn.tlast !== 1'b0) begin errors++; $display("FAIL bcast_idle: got vld=%b last=%b, want 0 0", dn.vld, dn.tlast); end
  endtask

  task automatic test_unicast();
    int nw;
    cap_q.delete(); ren_last = 0; req_cnt = 0; rip_seen = 0;
    send_pkt(0, 16, 8'h10, 0, 0);
    wait_tlasts(1);
    check_frame("ucast", ARP_MAC, TGT, 16, 8'h10, 16'h0000, nw);
    checks++;
    if (got[4][36:5] !== 32'h0024_0000) begin errors++; $display("FAIL ucast_w4: got %h, want 00240000", got[4][36:5]); end
    checks++;
    if (got[6][36:5] !== 32'hF76C_C0A8) begin errors++; $display("FAIL ucast_w6: got %h, want f76cc0a8", got[6][36:5]); end
    checks++;
    if (got[12][4:0] !== {4'hC, 1'b1}) begin errors++; $display("FAIL ucast_last: got be=%h last=%b, want be=c last=1", got[12][4:1], got[12][0]); end
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL ucast_extra: got %0d extra words, want 0", cap_q.size()); end
    checks++;
    if (ren_last != 3 || rip_seen !== TGT) begin errors++; $display("FAIL ucast_arp: got r_en cycles=%0d ip=%h, want 3 %h", ren_last, rip_seen, TGT); end
    checks++;
    if (req_cnt != 1) begin errors++; $display("FAIL ucast_req: got %0d requests, want 1", req_cnt); end
  endtask

  task automatic test_arp_timeout();
    cap_q.delete(); ren_last = 0; req_cnt = 0; arp_hit = 0;
    send_pkt(0, 10, 8'h30, 0, 0);
    @(posedge clk); #1;
    arp_hit = 1;
    checks++;
    if (ren_last != 255 || r_en !== 1'b0) begin errors++; $display("FAIL tmo_ren: got r_en cycles=%0d r_en=%b, want 255 0", ren_last, r_en); end
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL tmo_drop: got %0d, want 1", drop_cnt); end
    checks++;
    if (req_cnt != 0) begin errors++; $display("FAIL tmo_req: got %0d requests, want 0", req_cnt); end
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL tmo_words: got %0d words, want 0", cap_q.size()); end
  endtask

  task automatic test_backpressure();
    int nw;
    cap_q.delete();
    toggle = 1;
    send_pkt(0, 13, 8'h50, 1, 0);
    wait_tlasts(1);
    toggle = 0;
    check_frame("bp", ARP_MAC, TGT, 13, 8'h50, 16'h0001, nw);
    checks++;
    if (got[11][4:0] !== {4'hE, 1'b1}) begin errors++; $display("FAIL bp_last: got be=%h last=%b, want be=e last=1", got[11][4:1], got[11][0]); end
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL bp_extra: got %0d extra words, want 0", cap_q.size()); end
  endtask

  task automatic test_back_to_back();
    int nw;
    logic [15:0] id_a;
    cap_q.delete();
    send_pkt(0, 8, 8'h60, 0, 0);
    send_pkt(0, 20, 8'h70, 0, 0);
    wait_tlasts(2);
    check_frame("b2b_a", ARP_MAC, TGT, 8, 8'h60, 16'h0002, nw);
    id_a = got[4][20:5];
    check_frame("b2b_b", ARP_MAC, TGT, 20, 8'h70, 16'h0003, nw);
    checks++;
    if (got[4][20:5] !== id_a + 16'd1) begin errors++; $display("FAIL b2b_ident: got %h, want %h", got[4][20:5], id_a + 16'd1); end
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra words, want 0", cap_q.size()); end
  endtask

  task automatic test_reset_mid();
    int nw;
    cap_q.delete();
    send_pkt(0, 32, 8'h80, 0, 3);
    reset_n = 0;
    @(posedge clk); #1;
    checks++;
    if ({dn.vld, dn.data, dn.be, dn.tlast, req, r_en, rip, up.ready, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got vld=%b data=%h be=%h last=%b req=%b ren=%b rip=%h rdy=%b drop=%h, want all 0",
               dn.vld, dn.data, dn.be, dn.tlast, req, r_en, rip, up.ready, drop_cnt);
    end
    checks++;
    if (count_tl() != 0) begin errors++; $display("FAIL midrst_tlast: got %0d tlast words, want 0", count_tl()); end
    reset_n = 1;
    cap_q.delete();
    @(posedge clk); #1;
    send_pkt(0, 16, 8'h90, 0, 0);
    wait_tlasts(1);
    check_frame("post_rst", ARP_MAC, TGT, 16, 8'h90, 16'hFFFF, nw);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL post_rst_extra: got %0d extra words, want 0", cap_q.size()); end
  endtask

  initial begin
    up.vld = 0;
    up.data = '0;
    up.be = '0;
    up.tlast = 0;
    test_reset();
    test_broadcast();
    test_unicast();
    test_arp_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
